// File: rtl/pic_host_if.sv
// Host-side bundle for pic_host: PIC control strobes, CPU register-access
// handshake and interrupt-vector hand-off. The PIC data bus is a separate
// inout port on pic_host.
interface pic_host_if;
   // PIC side ("int" is a keyword, so the request line is intr)
   logic [1:0] select;
   logic       readwrite;
   logic       intack;
   logic       intr;
   // CPU register-access side
   logic       req;
   logic       req_we;
   logic [1:0] req_sel;
   logic [7:0] req_wdata;
   logic       req_ack;
   logic [7:0] req_rdata;
   // Interrupt service side
   logic       vec_valid;
   logic [7:0] vec;
   logic       done;
   logic       busy;

   modport master (
      output select, readwrite, intack, req_ack, req_rdata, vec_valid, vec, busy,
      input  intr, req, req_we, req_sel, req_wdata, done
   );

   modport slave (
      input  select, readwrite, intack, req_ack, req_rdata, vec_valid, vec, busy,
      output intr, req, req_we, req_sel, req_wdata, done
   );
endinterface

// File: rtl/pic_host.sv
// Host-side sequencer for an 8-bit PIC: serves CPU register reads/writes and
// runs the interrupt acknowledge / service / end-of-interrupt sequence.
module pic_host #(
   parameter logic [7:0] EOI_CMD  = 8'h20,
   parameter bit         AUTO_EOI = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   inout  wire  [7:0] data,
   pic_host_if.master bus
);

   typedef enum logic [2:0] {
      StIdle, StWr, StRd1, StRd2, StAck1, StAck2, StServ, StEoi
   } state_e;

   state_e     r_state;
   state_e     w_state_next;

   logic [1:0] r_sel;
   logic [7:0] r_wdata;
   logic       r_req_ack;
   logic [7:0] r_req_rdata;
   logic [7:0] r_vec;
   logic       r_vec_valid;

   logic [1:0] w_select;
   logic       w_readwrite;
   logic       w_intack;
   logic       w_oe;
   logic [7:0] w_dout;
   logic       w_accept;
   logic       w_vec_clear;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   // Next-state: interrupts beat CPU requests; the ack cycle itself never
   // re-accepts the still-held request
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (bus.intr)                  w_state_next = StAck1;
            else if (bus.req && !r_req_ack) w_state_next = bus.req_we ? StWr : StRd1;
         end
         StWr:   w_state_next = StIdle;
         StRd1:  w_state_next = StRd2;
         StRd2:  w_state_next = StIdle;
         StAck1: w_state_next = StAck2;
         StAck2: w_state_next = AUTO_EOI ? StEoi : StServ;
         StServ: if (bus.done) w_state_next = StEoi;
         StEoi:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Bus outputs decoded from state; idle bus is select=00, read, no intack
   always_comb begin
      w_select    = 2'b00;
      w_readwrite = 1'b1;
      w_intack    = 1'b0;
      w_oe        = 1'b0;
      w_dout      = 8'h00;
      case (r_state)
         StWr: begin
            w_select    = r_sel;
            w_readwrite = 1'b0;
            w_oe        = 1'b1;
            w_dout      = r_wdata;
         end
         StRd1, StRd2: w_select = r_sel;
         StAck1, StAck2: w_intack = 1'b1;
         StEoi: begin
            w_readwrite = 1'b0;
            w_oe        = 1'b1;
            w_dout      = EOI_CMD;
         end
         default: ;
      endcase
   end

   assign w_accept = (r_state == StIdle) && ((w_state_next == StWr) || (w_state_next == StRd1));

   // Without auto-EOI the vector lives until its EOI; with auto-EOI the EOI is
   // already out, so the CPU's done is what retires the vector
   assign w_vec_clear = AUTO_EOI ? bus.done : (r_state == StEoi);

   // Latch the request fields when an access is accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sel   <= 2'b00;
         r_wdata <= 8'h00;
      end else if (w_accept) begin
         r_sel   <= bus.req_sel;
         r_wdata <= bus.req_wdata;
      end
   end

   // Access completion: one-cycle ack after WR/RD2, read data sampled ending RD2
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_req_ack   <= 1'b0;
         r_req_rdata <= 8'h00;
      end else begin
         r_req_ack <= (r_state == StWr) || (r_state == StRd2);
         if (r_state == StRd2) r_req_rdata <= data;
      end
   end

   // Vector capture on the edge ending ACK2; capture wins over a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vec       <= 8'h00;
         r_vec_valid <= 1'b0;
      end else if (r_state == StAck2) begin
         r_vec       <= data;
         r_vec_valid <= 1'b1;
      end else if (w_vec_clear) begin
         r_vec_valid <= 1'b0;
      end
   end

   assign data          = w_oe ? w_dout : 8'hzz;
   assign bus.select    = w_select;
   assign bus.readwrite = w_readwrite;
   assign bus.intack    = w_intack;
   assign bus.req_ack   = r_req_ack;
   assign bus.req_rdata = r_req_rdata;
   assign bus.vec       = r_vec;
   assign bus.vec_valid = r_vec_valid;
   assign bus.busy      = (r_state != StIdle);

endmodule
